// File: rtl/mips_pkg.sv
// Shared encodings, ALU select codes and the decoded-entry record for the
// MIPS-subset ID/EX boundary.
package mips_pkg;

   localparam int WORD_W    = 32;
   localparam int ALU_SEL_W = 4;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [5:0] FN_DIV  = 6'b011010;

   localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'd2;
   localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'd3;
   localparam logic [ALU_SEL_W-1:0] ALU_SLT  = 4'd4;
   localparam logic [ALU_SEL_W-1:0] ALU_MUL  = 4'd5;
   localparam logic [ALU_SEL_W-1:0] ALU_DIV  = 4'd6;
   localparam logic [ALU_SEL_W-1:0] ALU_NOP  = 4'd7;
   localparam logic [ALU_SEL_W-1:0] ALU_ADDI = 4'd9;
   localparam logic [ALU_SEL_W-1:0] ALU_SLTI = 4'd10;
   localparam logic [ALU_SEL_W-1:0] ALU_ANDI = 4'd11;
   localparam logic [ALU_SEL_W-1:0] ALU_ORI  = 4'd12;

   typedef enum logic [1:0] {ST_EMPTY, ST_MAIN, ST_FULL} state_t;

   typedef struct packed {
      logic [WORD_W-1:0]    x;
      logic [WORD_W-1:0]    y;
      logic [ALU_SEL_W-1:0] sel;
      logic [4:0]           dest;
      logic                 reg_write;
      logic                 mem_read;
      logic                 mem_write;
      logic                 branch;
      logic [WORD_W-1:0]    store_data;
      logic                 illegal;
   } entry_t;

   function automatic logic [WORD_W-1:0] sign_ext(input logic [15:0] imm);
      return {{(WORD_W-16){imm[15]}}, imm};
   endfunction

   function automatic logic [WORD_W-1:0] zero_ext(input logic [15:0] imm);
      return {{(WORD_W-16){1'b0}}, imm};
   endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational decoder: turns opcode/funct plus register and immediate
// fields into one fully decoded ALU/EX entry.
module id_decode
   import mips_pkg::*;
(
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   input  logic [WORD_W-1:0] rs_data,
   input  logic [WORD_W-1:0] rt_data,
   input  logic [15:0]       imm,
   input  logic [4:0]        rt_addr,
   input  logic [4:0]        rd_addr,
   output entry_t            entry
);

   always_comb begin
      // NOTE: every field gets a default first so no path leaves a latch.
      entry     = '0;
      entry.x   = rs_data;
      entry.y   = rt_data;
      entry.sel = ALU_NOP;

      case (opcode)
         OP_RTYPE: begin
            entry.dest      = rd_addr;
            entry.reg_write = 1'b1;
            case (funct)
               FN_ADD:  entry.sel = ALU_ADD;
               FN_SUB:  entry.sel = ALU_SUB;
               FN_AND:  entry.sel = ALU_AND;
               FN_OR:   entry.sel = ALU_OR;
               FN_SLT:  entry.sel = ALU_SLT;
               FN_MULT: entry.sel = ALU_MUL;
               FN_DIV:  entry.sel = ALU_DIV;
               default: entry.illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
            entry.dest      = rt_addr;
            entry.reg_write = 1'b1;
            case (opcode)
               OP_ADDI: begin entry.sel = ALU_ADDI; entry.y = sign_ext(imm); end
               OP_SLTI: begin entry.sel = ALU_SLTI; entry.y = sign_ext(imm); end
               OP_ANDI: begin entry.sel = ALU_ANDI; entry.y = zero_ext(imm); end
               default: begin entry.sel = ALU_ORI;  entry.y = zero_ext(imm); end
            endcase
         end
         OP_LW: begin
            entry.sel       = ALU_ADD;
            entry.y         = sign_ext(imm);
            entry.dest      = rt_addr;
            entry.mem_read  = 1'b1;
            entry.reg_write = 1'b1;
         end
         OP_SW: begin
            entry.sel        = ALU_ADD;
            entry.y          = sign_ext(imm);
            entry.mem_write  = 1'b1;
            entry.store_data = rt_data;
         end
         OP_BEQ: begin
            entry.sel    = ALU_SUB;
            entry.branch = 1'b1;
         end
         default: entry.illegal = 1'b1;
      endcase

      // Illegal entries still flow downstream but must not touch any state.
      if (entry.illegal) begin
         entry.x         = rs_data;
         entry.y         = rt_data;
         entry.sel       = ALU_NOP;
         entry.dest      = '0;
         entry.reg_write = 1'b0;
      end

      if (entry.dest == 5'd0) entry.reg_write = 1'b0;
   end

endmodule

// File: rtl/id_ex_issue_stage.sv
// Registered ID/EX boundary with a 2-entry skid buffer feeding the ALU.
// Optional ID_EX_STATS_EN adds issue/stall counters.
module id_ex_issue_stage
   import mips_pkg::*;
#(
   parameter int DATA_W = WORD_W,
   parameter int SEL_W  = ALU_SEL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_opcode,
   input  logic [5:0]        in_funct,
   input  logic [DATA_W-1:0] in_rs_data,
   input  logic [DATA_W-1:0] in_rt_data,
   input  logic [15:0]       in_imm,
   input  logic [4:0]        in_rt_addr,
   input  logic [4:0]        in_rd_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_x,
   output logic [DATA_W-1:0] alu_y,
   output logic [SEL_W-1:0]  alu_sel,
   output logic [4:0]        out_dest,
   output logic              out_reg_write,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_branch,
   output logic [DATA_W-1:0] out_store_data,
`ifdef ID_EX_STATS_EN
   output logic [31:0]       stat_issued,
   output logic [31:0]       stat_stall,
`endif
   output logic              out_illegal
);

   entry_t dec, main_q, skid_q;
   state_t state, state_n;
   logic   in_ready_q, out_valid_q;
   logic   accept, present, load_in, load_skid, skid_to_main;

   id_decode u_decode (
      .opcode  (in_opcode),
      .funct   (in_funct),
      .rs_data (in_rs_data),
      .rt_data (in_rt_data),
      .imm     (in_imm),
      .rt_addr (in_rt_addr),
      .rd_addr (in_rd_addr),
      .entry   (dec)
   );

   assign accept  = in_valid & in_ready_q;
   assign present = out_valid_q & out_ready;

   always_comb begin
      state_n      = state;
      load_in      = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
      case (state)
         ST_EMPTY: if (accept) begin state_n = ST_MAIN; load_in = 1'b1; end
         ST_MAIN: begin
            if (accept && present)      load_in = 1'b1;
            else if (accept)            begin state_n = ST_FULL; load_skid = 1'b1; end
            else if (present)           state_n = ST_EMPTY;
         end
         ST_FULL: if (present) begin state_n = ST_MAIN; skid_to_main = 1'b1; end
         default: state_n = ST_EMPTY;
      endcase
      if (flush) begin
         state_n      = ST_EMPTY;
         load_in      = 1'b0;
         load_skid    = 1'b0;
         skid_to_main = 1'b0;
      end
   end

   // Handshake flags are flopped from the next state so neither is combinational.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_n;
         in_ready_q  <= (state_n != ST_FULL);
         out_valid_q <= (state_n != ST_EMPTY);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            main_q <= '0;
      else if (load_in)      main_q <= dec;
      else if (skid_to_main) main_q <= skid_q;
   end

   // NOTE: skid is payload only; its validity lives in state, so it needs no reset.
   always_ff @(posedge clk) begin
      if (load_skid) skid_q <= dec;
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = out_valid_q;
   assign alu_x          = main_q.x;
   assign alu_y          = main_q.y;
   assign alu_sel        = main_q.sel;
   assign out_dest       = main_q.dest;
   assign out_reg_write  = main_q.reg_write;
   assign out_mem_read   = main_q.mem_read;
   assign out_mem_write  = main_q.mem_write;
   assign out_branch     = main_q.branch;
   assign out_store_data = main_q.store_data;
   assign out_illegal    = main_q.illegal;

`ifdef ID_EX_STATS_EN
   logic [31:0] issued_q, stall_q;

   // Counters survive flush; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_q <= '0;
         stall_q  <= '0;
      end else begin
         if (present)                   issued_q <= issued_q + 32'd1;
         if (out_valid_q && !out_ready) stall_q  <= stall_q + 32'd1;
      end
   end

   assign stat_issued = issued_q;
   assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Scoreboard bench for id_ex_issue_stage: directed vectors push expected
// entries; a negedge monitor compares every presented output in order.
module tb_id_ex_issue_stage;

   localparam int EW = 110;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [5:0]  in_opcode, in_funct;
   logic [31:0] in_rs_data, in_rt_data;
   logic [15:0] in_imm;
   logic [4:0]  in_rt_addr, in_rd_addr;
   logic [31:0] alu_x, alu_y, out_store_data;
   logic [3:0]  alu_sel;
   logic [4:0]  out_dest;
   logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal;
`ifdef ID_EX_STATS_EN
   logic [31:0] stat_issued, stat_stall;
`endif

   logic [EW-1:0] q[$];
   logic [EW-1:0] act;
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_ex_issue_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct(in_funct),
      .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
      .in_imm(in_imm), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel),
      .out_dest(out_dest), .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_branch(out_branch), .out_store_data(out_store_data),
`ifdef ID_EX_STATS_EN
      .stat_issued(stat_issued), .stat_stall(stat_stall),
`endif
      .out_illegal(out_illegal)
   );

   assign act = {alu_x, alu_y, alu_sel, out_dest, out_reg_write, out_mem_read,
                 out_mem_write, out_branch, out_store_data, out_illegal};

   function automatic logic [EW-1:0] mk(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] sel, input logic [4:0] dest,
                                        input logic rw, input logic mr, input logic mw,
                                        input logic br, input logic [31:0] sd,
                                        input logic ill);
      return {x, y, sel, dest, rw, mr, mw, br, sd, ill};
   endfunction

   task automatic check(input string name, input logic [EW-1:0] a, input logic [EW-1:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   task automatic check_bit(input string name, input logic a, input logic e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, a, e);
      end
   endtask

   // Monitor: while valid, the output must equal the queue head (also proves
   // stability under stall); it retires on the presenting edge.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %h expected no output", act);
         end else begin
            check("issue", act, q[0]);
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   task automatic send(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm, input logic [4:0] rta,
                       input logic [4:0] rda, input logic [EW-1:0] e);
      bit done = 1'b0;
      in_valid = 1'b1; in_opcode = op; in_funct = fn; in_rs_data = rs;
      in_rt_data = rt; in_imm = imm; in_rt_addr = rta; in_rd_addr = rda;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected accept");
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 40 && q.size() != 0; c++) @(posedge clk);
      @(posedge clk);
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d entries outstanding expected 0", q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_opcode = '0; in_funct = '0; in_rs_data = '0; in_rt_data = '0;
      in_imm = '0; in_rt_addr = '0; in_rd_addr = '0;

      #12;
      check_bit("rst_out_valid", out_valid, 1'b0);
      check_bit("rst_in_ready", in_ready, 1'b1);
      check("rst_outputs", act, '0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      check_bit("post_rst_out_valid", out_valid, 1'b0);
      check_bit("post_rst_in_ready", in_ready, 1'b1);

      // Streaming decode vectors with no backpressure.
      out_ready = 1'b1;
      send(6'b000000, 6'b100000, 5, 7, 16'h0000, 7, 3, mk(5, 7, 0, 3, 1, 0, 0, 0, 0, 0));
      send(6'b001000, 6'b000000, 10, 32'h1234, 16'hFFFF, 2, 0,
           mk(10, 32'hFFFFFFFF, 9, 2, 1, 0, 0, 0, 0, 0));
      send(6'b001101, 6'b000000, 1, 0, 16'hFFFF, 6, 0,
           mk(1, 32'h0000FFFF, 12, 6, 1, 0, 0, 0, 0, 0));
      send(6'b000000, 6'b100111, 9, 4, 16'h0000, 4, 8, mk(9, 4, 7, 0, 0, 0, 0, 0, 0, 1));
      send(6'b000100, 6'b000000, 3, 3, 16'h0010, 3, 0, mk(3, 3, 1, 0, 0, 0, 0, 1, 0, 0));
      send(6'b001000, 6'b000000, 4, 99, 16'h0005, 0, 0, mk(4, 5, 9, 0, 0, 0, 0, 0, 0, 0));
      send(6'b000000, 6'b100010, 20, 8, 16'h0000, 1, 9, mk(20, 8, 1, 9, 1, 0, 0, 0, 0, 0));
      send(6'b000000, 6'b100100, 6, 3, 16'h0000, 1, 10, mk(6, 3, 2, 10, 1, 0, 0, 0, 0, 0));
      send(6'b000000, 6'b100101, 6, 3, 16'h0000, 1, 11, mk(6, 3, 3, 11, 1, 0, 0, 0, 0, 0));
      send(6'b000000, 6'b101010, 6, 3, 16'h0000, 1, 12, mk(6, 3, 4, 12, 1, 0, 0, 0, 0, 0));
      send(6'b001010, 6'b000000, 1, 0, 16'h8000, 5, 0,
           mk(1, 32'hFFFF8000, 10, 5, 1, 0, 0, 0, 0, 0));
      send(6'b001100, 6'b000000, 2, 0, 16'h8000, 7, 0,
           mk(2, 32'h00008000, 11, 7, 1, 0, 0, 0, 0, 0));
      send(6'b101011, 6'b000000, 100, 32'hDEADBEEF, 16'hFFFC, 3, 0,
           mk(100, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 0));
      send(6'b000000, 6'b011000, 3, 4, 16'h0000, 4, 5, mk(3, 4, 5, 5, 1, 0, 0, 0, 0, 0));
      send(6'b000000, 6'b011010, 12, 4, 16'h0000, 4, 6, mk(12, 4, 6, 6, 1, 0, 0, 0, 0, 0));
      send(6'b000000, 6'b100000, 1, 2, 16'h0000, 2, 0, mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      send(6'b111111, 6'b100000, 5, 6, 16'h1234, 6, 7, mk(5, 6, 7, 0, 0, 0, 0, 0, 0, 1));
      drain();

      // Backpressure: two held, third waits until out_ready rises.
      out_ready = 1'b0;
      send(6'b000000, 6'b100000, 11, 1, 16'h0000, 1, 1, mk(11, 1, 0, 1, 1, 0, 0, 0, 0, 0));
      send(6'b000000, 6'b100000, 22, 2, 16'h0000, 2, 2, mk(22, 2, 0, 2, 1, 0, 0, 0, 0, 0));
      check_bit("bp_in_ready_full", in_ready, 1'b0);
      check_bit("bp_out_valid", out_valid, 1'b1);
      fork
         send(6'b000000, 6'b100000, 33, 3, 16'h0000, 3, 3, mk(33, 3, 0, 3, 1, 0, 0, 0, 0, 0));
         begin
            repeat (2) @(posedge clk);
            #1;
            check_bit("bp_third_waits", in_ready, 1'b0);
            out_ready = 1'b1;
         end
      join
      drain();

      // Flush while FULL with a pending offer, then a load.
      out_ready = 1'b0;
      send(6'b000000, 6'b100000, 1, 1, 16'h0000, 1, 1, mk(1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
      send(6'b000000, 6'b100000, 2, 2, 16'h0000, 2, 2, mk(2, 2, 0, 2, 1, 0, 0, 0, 0, 0));
      in_valid = 1'b1; in_opcode = 6'b000000; in_funct = 6'b100000;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      q.delete();
      check_bit("flush_full_out_valid", out_valid, 1'b0);
      check_bit("flush_full_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      send(6'b100011, 6'b000000, 32'h40, 32'h55, 16'h0008, 4, 0,
           mk(32'h40, 8, 0, 4, 1, 1, 0, 0, 0, 0));
      drain();

      // Flush in MAIN while an accept would happen: the new entry is dropped.
      out_ready = 1'b0;
      send(6'b000000, 6'b100010, 9, 9, 16'h0000, 9, 9, mk(9, 9, 1, 9, 1, 0, 0, 0, 0, 0));
      in_valid = 1'b1; in_opcode = 6'b001000; in_imm = 16'h0001; in_rt_addr = 5'd1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      q.delete();
      check_bit("flush_main_out_valid", out_valid, 1'b0);
      check_bit("flush_main_in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send(6'b000000, 6'b100101, 7, 8, 16'h0000, 8, 4, mk(7, 8, 3, 4, 1, 0, 0, 0, 0, 0));
      drain();

      // Asynchronous reset mid-stream with both entries held.
      out_ready = 1'b0;
      send(6'b000000, 6'b100000, 5, 5, 16'h0000, 5, 5, mk(5, 5, 0, 5, 1, 0, 0, 0, 0, 0));
      send(6'b001101, 6'b000000, 6, 0, 16'h00F0, 6, 0, mk(6, 32'hF0, 12, 6, 1, 0, 0, 0, 0, 0));
      #2 rst_n = 1'b0;
      #1;
      check_bit("midrst_out_valid", out_valid, 1'b0);
      check_bit("midrst_in_ready", in_ready, 1'b1);
      check("midrst_outputs", act, '0);
      q.delete();
      #8 rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(6'b000000, 6'b100000, 5, 7, 16'h0000, 7, 3, mk(5, 7, 0, 3, 1, 0, 0, 0, 0, 0));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
